// File: rtl/lz77_comp_stream.sv
// Greedy LZ77 compressor: AXI-Stream bytes in, {dist,len,lit} tokens out.
// A circular buffer keeps recent history plus a lookahead window. Each
// token is found by a brute-force search of one byte compare per cycle.
// Optional build macro LZ77_COMP_STATS_EN adds token and byte counters.
module lz77_comp_stream #(
  parameter int DIST_WIDTH        = 4,
  parameter int LEN_WIDTH         = 4,
  parameter int WINDOW_ADDR_WIDTH = 4,
  parameter int TOKEN_W           = DIST_WIDTH + LEN_WIDTH + 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tlast,
  output logic [TOKEN_W-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast
`ifdef LZ77_COMP_STATS_EN
  ,
  output logic [31:0]        stat_tokens,
  output logic [31:0]        stat_bytes
`endif
);

  localparam int DMAX_D = (2 ** DIST_WIDTH) - 1;
  localparam int DMAX_W = (2 ** WINDOW_ADDR_WIDTH) - 1;
  localparam int DMAX   = (DMAX_D < DMAX_W) ? DMAX_D : DMAX_W;
  localparam int LMAX   = (2 ** LEN_WIDTH) - 1;
  localparam int LA_MAX = 2 ** LEN_WIDTH;
  localparam int AW     = $clog2(DMAX + LA_MAX);
  localparam int DEPTH  = 2 ** AW;
  localparam int LW1    = LEN_WIDTH + 1;
  localparam int HW     = $clog2(DMAX + 1);
  localparam int SW     = AW + 1;
  localparam int CW     = (DIST_WIDTH > HW) ? DIST_WIDTH : HW;

  localparam logic [1:0] FILL   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] EMIT   = 2'd2;

  logic [7:0]            mem [DEPTH];
  logic [1:0]            state_reg;
  logic [AW-1:0]         pos_reg;
  logic [LW1-1:0]        la_cnt_reg;
  logic [HW-1:0]         hist_cnt_reg;
  logic                  last_seen_reg;
  logic [DIST_WIDTH-1:0] d_reg, best_d_reg;
  logic [LEN_WIDTH-1:0]  k_reg, best_reg;
  logic [TOKEN_W-1:0]    m_data_reg;
  logic                  m_valid_reg, m_last_reg;

  logic                  s_hs;
  logic [LW1-1:0]        la_m1;
  logic [LEN_WIDTH-1:0]  limit;
  logic [AW-1:0]         hist_addr, la_addr, lit_addr;
  logic                  byte_match, cand_done, cand_better, no_search, search_exit;
  logic [LEN_WIDTH-1:0]  k_inc, k_end, best_now, fin_best;
  logic [DIST_WIDTH-1:0] best_d_now, fin_d;
  logic [LW1-1:0]        fin_len_p1, emit_len_p1;
  logic                  tlast_now;
  logic [SW-1:0]         hist_sum;
  logic [HW-1:0]         hist_next;

  assign s_axis_tready = !rst && (state_reg == FILL) && (la_cnt_reg < LW1'(LA_MAX)) && !last_seen_reg;
  assign s_hs          = s_axis_tready && s_axis_tvalid;
  assign m_axis_tvalid = m_valid_reg && !rst;
  assign m_axis_tdata  = rst ? '0 : m_data_reg;
  assign m_axis_tlast  = m_last_reg && !rst;

  // Search datapath: one candidate byte compare per cycle and best-match tracking.
  always_comb begin
    la_m1       = la_cnt_reg - LW1'(1);
    limit       = (la_m1 > LW1'(LMAX)) ? LEN_WIDTH'(LMAX) : la_m1[LEN_WIDTH-1:0];
    hist_addr   = pos_reg - AW'(d_reg) + AW'(k_reg);
    la_addr     = pos_reg + AW'(k_reg);
    byte_match  = (mem[hist_addr] == mem[la_addr]);
    k_inc       = k_reg + LEN_WIDTH'(1);
    k_end       = byte_match ? k_inc : k_reg;
    cand_done   = !byte_match || (k_end == limit);
    cand_better = cand_done && (k_end > best_reg);
    best_now    = cand_better ? k_end : best_reg;
    best_d_now  = cand_better ? d_reg : best_d_reg;
    // No history or a single lookahead byte: the token is a bare literal.
    no_search   = (hist_cnt_reg == '0) || (limit == '0);
    fin_best    = no_search ? '0 : best_now;
    fin_d       = (fin_best == '0) ? '0 : best_d_now;
    search_exit = no_search ||
                  (cand_done && ((best_now == limit) || (CW'(d_reg) >= CW'(hist_cnt_reg))));
    lit_addr    = pos_reg + AW'(fin_best);
    fin_len_p1  = LW1'(fin_best) + LW1'(1);
    tlast_now   = last_seen_reg && (la_cnt_reg == fin_len_p1);
    emit_len_p1 = LW1'(best_reg) + LW1'(1);
    hist_sum    = SW'(hist_cnt_reg) + SW'(emit_len_p1);
    hist_next   = (hist_sum > SW'(DMAX)) ? HW'(DMAX) : hist_sum[HW-1:0];
  end

  // Byte buffer: accepted bytes land just past the current lookahead.
  always_ff @(posedge clk) begin
    if (s_hs) begin
      mem[pos_reg + AW'(la_cnt_reg)] <= s_axis_tdata;
    end
  end

  // Control FSM: fill lookahead, search for the longest match, emit one token.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= FILL;
      pos_reg       <= '0;
      la_cnt_reg    <= '0;
      hist_cnt_reg  <= '0;
      last_seen_reg <= 1'b0;
      d_reg         <= '0;
      k_reg         <= '0;
      best_reg      <= '0;
      best_d_reg    <= '0;
      m_data_reg    <= '0;
      m_valid_reg   <= 1'b0;
      m_last_reg    <= 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          if ((la_cnt_reg == LW1'(LA_MAX)) || (last_seen_reg && (la_cnt_reg != '0))) begin
            state_reg  <= SEARCH;
            d_reg      <= DIST_WIDTH'(1);
            k_reg      <= '0;
            best_reg   <= '0;
            best_d_reg <= '0;
          end else if (s_hs) begin
            la_cnt_reg <= la_cnt_reg + LW1'(1);
            if (s_axis_tlast) begin
              last_seen_reg <= 1'b1;
            end
          end
        end
        SEARCH: begin
          if (search_exit) begin
            state_reg   <= EMIT;
            best_reg    <= fin_best;
            best_d_reg  <= fin_d;
            m_valid_reg <= 1'b1;
            m_data_reg  <= {fin_d, fin_best, mem[lit_addr]};
            m_last_reg  <= tlast_now;
          end else if (cand_done) begin
            d_reg      <= d_reg + DIST_WIDTH'(1);
            k_reg      <= '0;
            best_reg   <= best_now;
            best_d_reg <= best_d_now;
          end else begin
            k_reg <= k_inc;
          end
        end
        EMIT: begin
          if (m_axis_tready) begin
            state_reg   <= FILL;
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            m_last_reg  <= 1'b0;
            pos_reg     <= pos_reg + AW'(emit_len_p1);
            if (m_last_reg) begin
              la_cnt_reg    <= '0;
              hist_cnt_reg  <= '0;
              last_seen_reg <= 1'b0;
            end else begin
              la_cnt_reg   <= la_cnt_reg - emit_len_p1;
              hist_cnt_reg <= hist_next;
            end
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

`ifdef LZ77_COMP_STATS_EN
  logic [31:0] stat_tokens_reg, stat_bytes_reg;
  assign stat_tokens = stat_tokens_reg;
  assign stat_bytes  = stat_bytes_reg;

  // Free-running handshake counters; they span frames and wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_tokens_reg <= '0;
      stat_bytes_reg  <= '0;
    end else begin
      if (m_valid_reg && m_axis_tready) begin
        stat_tokens_reg <= stat_tokens_reg + 32'd1;
      end
      if (s_hs) begin
        stat_bytes_reg <= stat_bytes_reg + 32'd1;
      end
    end
  end
`endif

endmodule
